// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with frame phase-lock to an RX sync pulse
// Optional saturating resync counter built only when VTG_MISS_COUNT_EN is defined.
module video_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_LINE   = 0,
    parameter int BUF_LINES   = 16,
    parameter int REPEAT_LOG2 = 0,
    parameter int READ_LAT    = 1,
    parameter int ADDR_W      = 14,
    parameter int LOST_FRAMES = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_sync,
    input  logic              i_sync_en,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_visible,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [11:0]       o_h_count,
    output logic [10:0]       o_v_count,
    output logic              o_frame_start,
    output logic              o_locked,
    output logic [7:0]        o_miss_count
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int REP_W    = (REPEAT_LOG2 > 0) ? REPEAT_LOG2 : 1;
    localparam int LOST_W   = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;

    localparam logic [11:0]       H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [10:0]       V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0]       V_LOCK    = 11'(LOCK_LINE);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'((1 << REPEAT_LOG2) - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_VISIBLE);
    localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'((BUF_LINES - 1) * H_VISIBLE);
    localparam logic [LOST_W-1:0] LOST_MAX  = LOST_W'(LOST_FRAMES - 1);
    // Buffer position a reload to LOCK_LINE lands on, so a non-zero lock line still reads the right line.
    localparam logic [ADDR_W-1:0] LOCK_BASE = (LOCK_LINE < V_VISIBLE) ?
        ADDR_W'(((LOCK_LINE >> REPEAT_LOG2) % BUF_LINES) * H_VISIBLE) : '0;
    localparam logic [REP_W-1:0]  LOCK_REP  = (LOCK_LINE < V_VISIBLE) ?
        REP_W'(LOCK_LINE % (1 << REPEAT_LOG2)) : '0;

    typedef enum logic {
        ST_FREE_RUN,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    logic                r_locked;
    logic [LOST_W-1:0]   r_lost;
    logic [11:0]         r_h;
    logic [10:0]         r_v;
    logic                r_sync_d;
    logic [ADDR_W-1:0]   r_base;
    logic [REP_W-1:0]    r_rep;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_fs;
    logic [READ_LAT:0]   r_hs_p;
    logic [READ_LAT:0]   r_vs_p;
    logic [READ_LAT:0]   r_vis_p;

    logic                w_h_last;
    logic                w_v_last;
    logic                w_frame_wrap;
    logic                w_edge;
    logic [11:0]         w_h_nat;
    logic [10:0]         w_v_nat;
    logic [11:0]         w_h_next;
    logic [10:0]         w_v_next;
    logic                w_vis;
    logic                w_hs;
    logic                w_vs;
    logic [ADDR_W-1:0]   w_step_base;

    assign w_h_last     = (r_h == H_LAST);
    assign w_v_last     = (r_v == V_LAST);
    assign w_frame_wrap = w_h_last && w_v_last;
    assign w_edge       = i_sync_en && i_sync && !r_sync_d;
    assign w_h_nat      = w_h_last ? 12'd0 : r_h + 12'd1;
    assign w_v_nat      = !w_h_last ? r_v : (w_v_last ? 11'd0 : r_v + 11'd1);
    assign w_h_next     = w_edge ? 12'd0 : w_h_nat;
    assign w_v_next     = w_edge ? V_LOCK : w_v_nat;
    assign w_vis        = (r_h < 12'(H_VISIBLE)) && (r_v < 11'(V_VISIBLE));
    assign w_hs         = ((r_h >= 12'(HS_START)) && (r_h < 12'(HS_END))) ? HS_POL : ~HS_POL;
    assign w_vs         = ((r_v >= 11'(VS_START)) && (r_v < 11'(VS_END))) ? VS_POL : ~VS_POL;
    assign w_step_base  = (r_base == BASE_LAST) ? '0 : r_base + LINE_STEP;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h      <= '0;
            r_v      <= '0;
            // Starts high so a SYNC level already high at reset release is not taken as an edge.
            r_sync_d <= 1'b1;
            r_base   <= '0;
            r_rep    <= '0;
            r_addr   <= '0;
            r_fs     <= 1'b0;
            r_hs_p   <= {(READ_LAT + 1){~HS_POL}};
            r_vs_p   <= {(READ_LAT + 1){~VS_POL}};
            r_vis_p  <= '0;
        end else if (i_enable) begin
            r_sync_d <= i_sync;
            r_h      <= w_h_next;
            r_v      <= w_v_next;
            r_fs     <= (w_h_next == 12'd0) && (w_v_next == 11'd0);
            if (w_vis) begin
                r_addr <= r_base + ADDR_W'(r_h);
            end
            if (w_edge) begin
                r_base <= LOCK_BASE;
                r_rep  <= LOCK_REP;
            end else if (w_h_last) begin
                if (w_v_nat == 11'd0) begin
                    r_base <= '0;
                    r_rep  <= '0;
                end else if (r_v < 11'(V_VISIBLE)) begin
                    if (r_rep == REP_MAX) begin
                        r_rep  <= '0;
                        r_base <= w_step_base;
                    end else begin
                        r_rep <= r_rep + REP_W'(1);
                    end
                end
            end
            r_hs_p[0]  <= w_hs;
            r_vs_p[0]  <= w_vs;
            r_vis_p[0] <= w_vis;
            for (int i = 1; i <= READ_LAT; i++) begin
                r_hs_p[i]  <= r_hs_p[i-1];
                r_vs_p[i]  <= r_vs_p[i-1];
                r_vis_p[i] <= r_vis_p[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_FREE_RUN;
            r_locked <= 1'b0;
            r_lost   <= '0;
        end else if (i_enable) begin
            case (r_state)
                ST_FREE_RUN: begin
                    if (w_edge) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                        r_lost   <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (!i_sync_en) begin
                        r_state  <= ST_FREE_RUN;
                        r_locked <= 1'b0;
                        r_lost   <= '0;
                    end else if (w_edge) begin
                        r_lost <= '0;
                    end else if (w_frame_wrap) begin
                        if (r_lost == LOST_MAX) begin
                            r_state  <= ST_FREE_RUN;
                            r_locked <= 1'b0;
                            r_lost   <= '0;
                        end else begin
                            r_lost <= r_lost + LOST_W'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_FREE_RUN;
                    r_locked <= 1'b0;
                    r_lost   <= '0;
                end
            endcase
        end
    end

`ifdef VTG_MISS_COUNT_EN
    logic       w_in_phase;
    logic [7:0] r_miss;

    assign w_in_phase = (w_h_nat == 12'd0) && (w_v_nat == V_LOCK);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_miss <= '0;
        end else if (i_enable && w_edge && !w_in_phase && (r_miss != 8'hFF)) begin
            r_miss <= r_miss + 8'd1;
        end
    end

    assign o_miss_count = r_miss;
`else
    assign o_miss_count = 8'd0;
`endif

    assign o_hs          = r_hs_p[READ_LAT];
    assign o_vs          = r_vs_p[READ_LAT];
    assign o_visible     = r_vis_p[READ_LAT];
    assign o_bram_addr   = r_addr;
    assign o_h_count     = r_h;
    assign o_v_count     = r_v;
    assign o_frame_start = r_fs;
    assign o_locked      = r_locked;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen (16x10 raster)
module tb_video_timing_gen;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HSY = 3;
    localparam int HB = 3;
    localparam int VV = 6;
    localparam int VF = 1;
    localparam int VSY = 2;
    localparam int VB = 1;
    localparam int HT = 16;
    localparam int VT = 10;
    localparam int FR = 160;
`ifdef VTG_MISS_COUNT_EN
    localparam bit MISS_ON = 1'b1;
`else
    localparam bit MISS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, sync, sync_en;
    logic        o_hs, o_vs, o_visible, o_frame_start, o_locked;
    logic [13:0] o_bram_addr;
    logic [11:0] o_h_count;
    logic [10:0] o_v_count;
    logic [7:0]  o_miss_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          g_n;
    logic [13:0] exp_addr;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .HS_POL(1'b0), .VS_POL(1'b1), .LOCK_LINE(0), .BUF_LINES(2),
        .REPEAT_LOG2(1), .READ_LAT(2), .ADDR_W(14), .LOST_FRAMES(3)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_sync(sync), .i_sync_en(sync_en),
        .o_hs(o_hs), .o_vs(o_vs), .o_visible(o_visible), .o_bram_addr(o_bram_addr),
        .o_h_count(o_h_count), .o_v_count(o_v_count), .o_frame_start(o_frame_start),
        .o_locked(o_locked), .o_miss_count(o_miss_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sync = 1'b0; sync_en = 1'b0;
        step(); step();
        n_cmp++; if (o_h_count !== 12'd0 || o_v_count !== 11'd0) begin n_bad++; $display("FAIL reset_hv: got %0d,%0d want 0,0", o_h_count, o_v_count); end
        n_cmp++; if ({o_hs, o_vs, o_visible} !== 3'b100) begin n_bad++; $display("FAIL reset_sync: got hs/vs/vis %b want 100", {o_hs, o_vs, o_visible}); end
        n_cmp++; if (o_bram_addr !== 14'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", o_bram_addr); end
        n_cmp++; if (o_frame_start !== 1'b0 || o_locked !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got fs=%b lk=%b want 0 0", o_frame_start, o_locked); end
        n_cmp++; if (o_miss_count !== 8'd0) begin n_bad++; $display("FAIL reset_miss: got %0d want 0", o_miss_count); end
    endtask

    task automatic test_free_run();
        int hc, vc;
        bit ehs, evs, evis;
        rst = 1'b0;
        g_n = 0;
        for (int k = 0; k < 2 * FR; k++) begin
            step();
            g_n++;
            n_cmp++; if (o_h_count !== 12'(g_n % HT) || o_v_count !== 11'((g_n / HT) % VT)) begin n_bad++; $display("FAIL fr_count n=%0d: got %0d,%0d want %0d,%0d", g_n, o_h_count, o_v_count, g_n % HT, (g_n / HT) % VT); end
            if (g_n >= 3) begin
                hc = (g_n - 3) % HT; vc = ((g_n - 3) / HT) % VT;
                ehs = !(hc >= HV + HF && hc < HV + HF + HSY);
                evs = (vc >= VV + VF && vc < VV + VF + VSY);
                evis = (hc < HV && vc < VV);
            end else begin
                ehs = 1'b1; evs = 1'b0; evis = 1'b0;
            end
            n_cmp++; if ({o_hs, o_vs, o_visible} !== {ehs, evs, evis}) begin n_bad++; $display("FAIL fr_sync n=%0d: got %b want %b", g_n, {o_hs, o_vs, o_visible}, {ehs, evs, evis}); end
            n_cmp++; if (o_frame_start !== ((g_n % FR) == 0)) begin n_bad++; $display("FAIL fr_fs n=%0d: got %b", g_n, o_frame_start); end
            n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL fr_locked n=%0d: got %b want 0", g_n, o_locked); end
        end
    endtask

    task automatic test_line_buffer();
        int hc, vc;
        bit evis;
        exp_addr = 14'd7;
        for (int k = 0; k < FR; k++) begin
            step();
            g_n++;
            hc = (g_n - 1) % HT; vc = ((g_n - 1) / HT) % VT;
            if (hc < HV && vc < VV) exp_addr = 14'(((vc / 2) % 2) * HV + hc);
            n_cmp++; if (o_bram_addr !== exp_addr) begin n_bad++; $display("FAIL lb_addr n=%0d: got %0d want %0d", g_n, o_bram_addr, exp_addr); end
            hc = (g_n - 3) % HT; vc = ((g_n - 3) / HT) % VT;
            evis = (hc < HV && vc < VV);
            n_cmp++; if (o_visible !== evis) begin n_bad++; $display("FAIL lb_vis n=%0d: got %b want %b", g_n, o_visible, evis); end
        end
    endtask

    task automatic test_lock();
        repeat (53) step();
        sync_en = 1'b1; sync = 1'b1;
        step();
        sync = 1'b0;
        n_cmp++; if (o_h_count !== 12'd0 || o_v_count !== 11'd0) begin n_bad++; $display("FAIL lock_hv: got %0d,%0d want 0,0", o_h_count, o_v_count); end
        n_cmp++; if (o_locked !== 1'b1 || o_frame_start !== 1'b1) begin n_bad++; $display("FAIL lock_flags: got lk=%b fs=%b want 1 1", o_locked, o_frame_start); end
        n_cmp++; if (o_miss_count !== 8'(MISS_ON ? 1 : 0)) begin n_bad++; $display("FAIL lock_miss: got %0d want %0d", o_miss_count, MISS_ON ? 1 : 0); end
        repeat (2) begin
            repeat (159) step();
            n_cmp++; if (o_h_count !== 12'd15 || o_v_count !== 11'd9) begin n_bad++; $display("FAIL inphase_pre: got %0d,%0d want 15,9", o_h_count, o_v_count); end
            sync = 1'b1;
            step();
            sync = 1'b0;
            n_cmp++; if (o_h_count !== 12'd0 || o_v_count !== 11'd0 || o_locked !== 1'b1) begin n_bad++; $display("FAIL inphase_hv: got %0d,%0d lk=%b want 0,0 1", o_h_count, o_v_count, o_locked); end
            n_cmp++; if (o_miss_count !== 8'(MISS_ON ? 1 : 0)) begin n_bad++; $display("FAIL inphase_miss: got %0d want %0d", o_miss_count, MISS_ON ? 1 : 0); end
        end
    endtask

    task automatic test_lost();
        for (int k = 1; k <= 3 * FR; k++) begin
            step();
            if (k == 1 || k == 3 * FR - 1) begin
                n_cmp++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL lost_held k=%0d: got %b want 1", k, o_locked); end
            end
            if (k == 3 * FR) begin
                n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL lost_drop: got %b want 0", o_locked); end
                n_cmp++; if (o_h_count !== 12'd0 || o_v_count !== 11'd0) begin n_bad++; $display("FAIL lost_hv: got %0d,%0d want 0,0", o_h_count, o_v_count); end
            end
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_cmp++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL relock: got %b want 1", o_locked); end
        sync_en = 1'b0;
        step();
        n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL syncen_drop: got %b want 0", o_locked); end
    endtask

    task automatic test_enable_hold();
        sync_en = 1'b1;
        step(); step();
        n_cmp++; if (o_h_count !== 12'd3) begin n_bad++; $display("FAIL hold_pre: got %0d want 3", o_h_count); end
        en = 1'b0; sync = 1'b1;
        repeat (4) step();
        n_cmp++; if (o_h_count !== 12'd3 || o_v_count !== 11'd0) begin n_bad++; $display("FAIL hold_hv: got %0d,%0d want 3,0", o_h_count, o_v_count); end
        n_cmp++; if ({o_hs, o_vs, o_visible, o_locked} !== 4'b1010) begin n_bad++; $display("FAIL hold_out: got %b want 1010", {o_hs, o_vs, o_visible, o_locked}); end
        n_cmp++; if (o_bram_addr !== 14'd2) begin n_bad++; $display("FAIL hold_addr: got %0d want 2", o_bram_addr); end
        en = 1'b1;
        step();
        sync = 1'b0;
        n_cmp++; if (o_h_count !== 12'd0 || o_v_count !== 11'd0 || o_locked !== 1'b1) begin n_bad++; $display("FAIL hold_edge: got %0d,%0d lk=%b want 0,0 1", o_h_count, o_v_count, o_locked); end
        n_cmp++; if (o_miss_count !== 8'(MISS_ON ? 3 : 0)) begin n_bad++; $display("FAIL hold_miss: got %0d want %0d", o_miss_count, MISS_ON ? 3 : 0); end
    endtask

    task automatic test_reset_mid();
        repeat (38) step();
        n_cmp++; if (o_h_count !== 12'd6 || o_v_count !== 11'd2) begin n_bad++; $display("FAIL rm_pre_hv: got %0d,%0d want 6,2", o_h_count, o_v_count); end
        n_cmp++; if (o_bram_addr !== 14'd13 || o_visible !== 1'b1) begin n_bad++; $display("FAIL rm_pre_addr: got %0d vis=%b want 13 1", o_bram_addr, o_visible); end
        rst = 1'b1;
        step();
        n_cmp++; if (o_h_count !== 12'd0 || o_v_count !== 11'd0) begin n_bad++; $display("FAIL rm_hv: got %0d,%0d want 0,0", o_h_count, o_v_count); end
        n_cmp++; if ({o_hs, o_vs, o_visible, o_frame_start, o_locked} !== 5'b10000) begin n_bad++; $display("FAIL rm_flags: got %b want 10000", {o_hs, o_vs, o_visible, o_frame_start, o_locked}); end
        n_cmp++; if (o_bram_addr !== 14'd0 || o_miss_count !== 8'd0) begin n_bad++; $display("FAIL rm_addr_miss: got %0d,%0d want 0,0", o_bram_addr, o_miss_count); end
        rst = 1'b0;
        step();
        n_cmp++; if (o_h_count !== 12'd1 || o_v_count !== 11'd0) begin n_bad++; $display("FAIL rm_resume: got %0d,%0d want 1,0", o_h_count, o_v_count); end
        step();
        n_cmp++; if (o_visible !== 1'b0) begin n_bad++; $display("FAIL rm_vis_early: got %b want 0", o_visible); end
        step();
        n_cmp++; if (o_visible !== 1'b1 || o_bram_addr !== 14'd2) begin n_bad++; $display("FAIL rm_vis: got vis=%b addr=%0d want 1 2", o_visible, o_bram_addr); end
    endtask

    task automatic test_miss_sat();
        int exp_miss;
        for (int i = 1; i <= 300; i++) begin
            sync = 1'b1;
            step();
            sync = 1'b0;
            step();
            exp_miss = MISS_ON ? ((i > 255) ? 255 : i) : 0;
            n_cmp++; if (o_miss_count !== 8'(exp_miss)) begin n_bad++; $display("FAIL miss_sat i=%0d: got %0d want %0d", i, o_miss_count, exp_miss); end
        end
        n_cmp++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL miss_locked: got %b want 1", o_locked); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_line_buffer();
        test_lock();
        test_lost();
        test_enable_hold();
        test_reset_mid();
        test_miss_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
